writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Holds the MEM/WB pipeline register and selects the writeback result (ALU result or memory read data).
- Drives the register-file write port, counts retired instructions, and latches a processor halt.

Parameters:
- DATA_W, 16, datapath width for ALU result, read data and writeback result.
- ADDR_W, 4, register destination address width.
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock, the same clock the memory stage pipelines on.
- reset  input  1  asynchronous, active-low reset.
- stallW  input  1  hold the MEM/WB register contents this cycle.
- flushW  input  1  load a bubble into MEM/WB this cycle.
- validM  input  1  memory stage holds a real instruction.
- RegWriteM  input  1  instruction writes the register file.
- MemtoRegM  input  1  1 selects memory read data, 0 selects the ALU result.
- HaltM  input  1  instruction is HALT.
- destAddM  input  ADDR_W  destination register.
- alu_resultM  input  DATA_W  pass-through ALU result from the memory stage.
- MemReadDataM  input  DATA_W  memory read data; settled before the rising edge because memory updates on the negative edge.
- validW  output  1  WB holds a real instruction.
- RegWriteW  output  1  register-file write enable.
- destAddW  output  ADDR_W  register-file write address.
- ResultW  output  DATA_W  register-file write data; also used as the forwarding source.
- halted  output  1  processor halted.
- retire_count  output  COUNT_W  number of instructions retired.

Behaviour:
- Reset (reset=0, asynchronous):
  - validW=0, RegWriteW=0, destAddW=0, ResultW=0, retire_count=0, halted=0.
  - Internal MemtoRegW, HaltW and both captured data registers are cleared.
  - FSM enters RUN.
- FSM has two states, RUN and HALTED.
- RUN, at each rising clk edge, in priority order:
  - flushW=1 loads a bubble: validW=0, RegWriteW=0; other fields don't-care, cleared to 0. flush beats stall.
  - Otherwise stallW=1 holds every register, and the counter does not change.
  - Otherwise capture validM, RegWriteM&validM&~HaltM, MemtoRegM, HaltM&validM, destAddM, alu_resultM and MemReadDataM.
- ResultW is combinational from registered state: MemtoRegW ? captured read data : captured ALU result. There is no extra latency; an instruction's result is visible the cycle after capture.
- Latency: 1 cycle from M inputs to W outputs.
- retire_count increments by 1 on every capture edge (no flush, no stall) where validM=1 and HaltM=0.
  - Wraps from 2^COUNT_W-1 to 0 without saturating.
- Halt:
  - A capture with validM=1 and HaltM=1 moves RUN to HALTED on that same edge.
  - halted=1 from the following cycle; the HALT itself never writes a register and is not counted.
- HALTED:
  - All MEM/WB registers are frozen with validW=0 and RegWriteW=0, forced on the halting edge.
  - stallW, flushW and all M inputs are ignored; retire_count is frozen.
  - HALTED is left only by reset.
- Simultaneous flushW=1 and a HALT at validM: the flush wins, the HALT is discarded and the state stays RUN.
- Reset asserted mid-stall or in HALTED: all outputs return to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: WB_R0_ZERO_EN.
- Defined: register 0 is hard-wired zero.
  - RegWriteW is forced to 0 whenever destAddW==0.
  - The instruction is still counted in retire_count.
- Undefined: destAddW==0 is written like any other register.

Test Plan:
- Reset, then capture validM=1, RegWriteM=1, MemtoRegM=0, destAddM=3, alu_resultM=0x1234 -> next cycle validW=1, RegWriteW=1, destAddW=3, ResultW=0x1234, retire_count=1.
- Capture MemtoRegM=1, MemReadDataM=0xBEEF, alu_resultM=0x0040 -> ResultW=0xBEEF. Then hold stallW=1 for 3 cycles with new M values -> outputs unchanged and retire_count unchanged.
- Assert flushW=1 and stallW=1 together with validM=1 -> validW=0, RegWriteW=0, count unchanged.
- Force retire_count to 0xFFFF via 65535 captures, then capture one more valid instruction -> retire_count=0x0000.
- Capture validM=1, HaltM=1, RegWriteM=1 -> halted=1 next cycle, RegWriteW=0. Further valid captures -> no change. Pulse reset low -> halted=0, count=0 asynchronously.
- Capture destAddM=0, RegWriteM=1, value 0x00FF -> with WB_R0_ZERO_EN, RegWriteW=0 and count increments; without it, RegWriteW=1 and ResultW=0x00FF.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, result select, register-file write port, retire counter, halt latch.
// Latency 1 cycle M->W; stallW holds, flushW bubbles; `WB_R0_ZERO_EN makes register 0 read-only.
module writeback_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stallW,
  input  logic               flushW,
  input  logic               validM,
  input  logic               RegWriteM,
  input  logic               MemtoRegM,
  input  logic               HaltM,
  input  logic [ADDR_W-1:0]  destAddM,
  input  logic [DATA_W-1:0]  alu_resultM,
  input  logic [DATA_W-1:0]  MemReadDataM,
  output logic               validW,
  output logic               RegWriteW,
  output logic [ADDR_W-1:0]  destAddW,
  output logic [DATA_W-1:0]  ResultW,
  output logic               halted,
  output logic [COUNT_W-1:0] retire_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state, state_nxt;
  logic                capture, bubble;
  logic                valid_q, regwrite_q, memtoreg_q, halt_q;
  logic [ADDR_W-1:0]   dest_q;
  logic [DATA_W-1:0]   alu_q, rdata_q;
  logic [COUNT_W-1:0]  count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Flush outranks stall; in HALTED neither the register nor the counter ever moves again.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    bubble    = 1'b0;
    if (state == RUN) begin
      if (flushW) begin
        bubble = 1'b1;
      end else if (!stallW) begin
        capture = 1'b1;
        if (validM && HaltM) state_nxt = HALTED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      halt_q     <= 1'b0;
      dest_q     <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      count_q    <= '0;
    end else if (bubble) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      halt_q     <= 1'b0;
      dest_q     <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
    end else if (capture) begin
      // A HALT lands as a non-valid, non-writing entry and is not retired.
      valid_q    <= validM & ~HaltM;
      regwrite_q <= RegWriteM & validM & ~HaltM;
      memtoreg_q <= MemtoRegM;
      halt_q     <= HaltM & validM;
      dest_q     <= destAddM;
      alu_q      <= alu_resultM;
      rdata_q    <= MemReadDataM;
      if (validM && !HaltM) count_q <= count_q + COUNT_W'(1);
    end
  end

  assign validW       = valid_q;
  assign destAddW     = dest_q;
  assign ResultW      = memtoreg_q ? rdata_q : alu_q;
  assign halted       = halt_q;
  assign retire_count = count_q;

`ifdef WB_R0_ZERO_EN
  assign RegWriteW = regwrite_q & (dest_q != '0);
`else
  assign RegWriteW = regwrite_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, halt/reset sequences, random run against a model, counter wrap.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stallW = 0, flushW = 0, validM = 0, RegWriteM = 0, MemtoRegM = 0, HaltM = 0;
  logic [3:0]  destAddM = 0;
  logic [15:0] alu_resultM = 0, MemReadDataM = 0;
  logic        validW, RegWriteW, halted;
  logic [3:0]  destAddW;
  logic [15:0] ResultW, retire_count;

  int total = 0;
  int bad   = 0;

`ifdef WB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  writeback_stage #(.DATA_W(16), .ADDR_W(4), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .stallW(stallW), .flushW(flushW), .validM(validM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .HaltM(HaltM), .destAddM(destAddM),
    .alu_resultM(alu_resultM), .MemReadDataM(MemReadDataM), .validW(validW),
    .RegWriteW(RegWriteW), .destAddW(destAddW), .ResultW(ResultW), .halted(halted),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s, f, v, rw, m2r, h;
    logic [3:0]  d;
    logic [15:0] alu, rd;
    logic        e_v, e_rw;
    logic [3:0]  e_d;
    logic [15:0] e_res, e_cnt;
    logic        e_halt;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of M inputs and return 1 time unit after the capturing edge.
  task automatic step(input logic s, f, v, rw, m2r, h, input logic [3:0] d,
                      input logic [15:0] alu, rd);
    stallW = s; flushW = f; validM = v; RegWriteM = rw; MemtoRegM = m2r; HaltM = h;
    destAddM = d; alu_resultM = alu; MemReadDataM = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", validW, 0);
    chk("rst_rw", RegWriteW, 0);
    chk("rst_dest", destAddW, 0);
    chk("rst_res", ResultW, 0);
    chk("rst_cnt", retire_count, 0);
    chk("rst_halt", halted, 0);
    #2;
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic s, f, v, rw, m2r, h, input logic [3:0] d,
                              input logic [15:0] alu, rd, input logic ev, erw,
                              input logic [3:0] ed, input logic [15:0] eres, ecnt,
                              input logic eh);
    vec_t r;
    r.s = s; r.f = f; r.v = v; r.rw = rw; r.m2r = m2r; r.h = h; r.d = d; r.alu = alu; r.rd = rd;
    r.e_v = ev; r.e_rw = erw; r.e_d = ed; r.e_res = eres; r.e_cnt = ecnt; r.e_halt = eh;
    return r;
  endfunction

  // Reference state of the WB stage, kept at transaction level.
  logic        m_valid, m_rw, m_halted;
  logic [3:0]  m_dest;
  logic [15:0] m_res, m_cnt;

  initial begin
    tbl[0]  = mk(0,0,1,1,0,0, 4'd3, 16'h1234, 16'h0000, 1,1, 4'd3, 16'h1234, 16'd1, 0);
    tbl[1]  = mk(0,0,1,1,1,0, 4'd5, 16'h0040, 16'hBEEF, 1,1, 4'd5, 16'hBEEF, 16'd2, 0);
    tbl[2]  = mk(1,0,1,1,0,0, 4'd7, 16'h1111, 16'h2222, 1,1, 4'd5, 16'hBEEF, 16'd2, 0);
    tbl[3]  = mk(1,0,1,0,0,0, 4'd8, 16'h3333, 16'h4444, 1,1, 4'd5, 16'hBEEF, 16'd2, 0);
    tbl[4]  = mk(1,0,0,1,1,1, 4'd9, 16'h5555, 16'h6666, 1,1, 4'd5, 16'hBEEF, 16'd2, 0);
    tbl[5]  = mk(1,1,1,1,0,0, 4'd6, 16'h7777, 16'h8888, 0,0, 4'd0, 16'h0000, 16'd2, 0);
    tbl[6]  = mk(0,0,1,0,0,0, 4'd9, 16'hAAAA, 16'h0101, 1,0, 4'd9, 16'hAAAA, 16'd3, 0);
    tbl[7]  = mk(0,0,0,1,0,0, 4'd2, 16'h5555, 16'h0202, 0,0, 4'd2, 16'h5555, 16'd3, 0);
    tbl[8]  = mk(0,0,1,1,0,0, 4'd0, 16'h00FF, 16'h0303, 1,!R0Z, 4'd0, 16'h00FF, 16'd4, 0);
    tbl[9]  = mk(0,1,1,1,0,1, 4'd1, 16'h0F0F, 16'h0404, 0,0, 4'd0, 16'h0000, 16'd4, 0);
    tbl[10] = mk(0,0,1,1,0,0, 4'd4, 16'h0777, 16'h0505, 1,1, 4'd4, 16'h0777, 16'd5, 0);

    #3;
    do_reset();
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].rw, tbl[i].m2r, tbl[i].h, tbl[i].d, tbl[i].alu, tbl[i].rd);
      chk($sformatf("v%0d_valid", i), validW, tbl[i].e_v);
      chk($sformatf("v%0d_rw", i), RegWriteW, tbl[i].e_rw);
      chk($sformatf("v%0d_dest", i), destAddW, tbl[i].e_d);
      chk($sformatf("v%0d_res", i), ResultW, tbl[i].e_res);
      chk($sformatf("v%0d_cnt", i), retire_count, tbl[i].e_cnt);
      chk($sformatf("v%0d_halt", i), halted, tbl[i].e_halt);
    end

    // Reset while stalled must clear outputs before any clock edge.
    stallW = 1'b1;
    do_reset();

    // Halt sequence: counted work, HALT, then everything ignored until reset.
    step(0,0,1,1,0,0, 4'd2, 16'h0011, 16'h0000);
    step(0,0,1,1,0,1, 4'd3, 16'h0022, 16'h0000);
    chk("halt_set", halted, 1);
    chk("halt_valid", validW, 0);
    chk("halt_rw", RegWriteW, 0);
    chk("halt_cnt", retire_count, 1);
    step(0,0,1,1,0,0, 4'd4, 16'h0033, 16'h0000);
    step(0,1,1,1,0,0, 4'd5, 16'h0044, 16'h0000);
    step(1,0,1,1,0,0, 4'd6, 16'h0055, 16'h0000);
    chk("halted_hold", halted, 1);
    chk("halted_valid", validW, 0);
    chk("halted_rw", RegWriteW, 0);
    chk("halted_cnt", retire_count, 1);
    do_reset();

    // Random traffic against the reference model.
    m_valid = 0; m_rw = 0; m_halted = 0; m_dest = 0; m_res = 0; m_cnt = 0;
    for (int n = 0; n < 800; n++) begin
      logic s, f, v, rw, m2r, h;
      logic [3:0]  d;
      logic [15:0] alu, rd;
      s = ($urandom_range(3) == 0); f = ($urandom_range(7) == 0);
      v = ($urandom_range(3) != 0); rw = $urandom_range(1); m2r = $urandom_range(1);
      h = ($urandom_range(47) == 0); d = 4'($urandom);
      alu = 16'($urandom); rd = 16'($urandom);
      step(s, f, v, rw, m2r, h, d, alu, rd);
      if (!m_halted && f) begin
        m_valid = 0; m_rw = 0; m_dest = 0; m_res = 0;
      end else if (!m_halted && !s) begin
        if (v && h) begin
          m_halted = 1; m_valid = 0; m_rw = 0;
        end else begin
          m_valid = v; m_rw = v & rw; m_dest = d; m_res = m2r ? rd : alu;
          if (v) m_cnt = m_cnt + 16'd1;
        end
      end
      chk("rnd_valid", validW, m_valid);
      chk("rnd_rw", RegWriteW, m_rw && !(R0Z && m_dest == 4'd0));
      chk("rnd_cnt", retire_count, m_cnt);
      chk("rnd_halt", halted, m_halted);
      if (!m_halted) begin
        chk("rnd_dest", destAddW, m_dest);
        chk("rnd_res", ResultW, m_res);
      end
      if (m_halted && $urandom_range(3) == 0) begin
        do_reset();
        m_valid = 0; m_rw = 0; m_halted = 0; m_dest = 0; m_res = 0; m_cnt = 0;
      end
    end

    // Counter wrap.
    do_reset();
    for (int n = 0; n < 65535; n++) step(0,0,1,0,0,0, 4'd1, 16'h0000, 16'h0000);
    chk("wrap_max", retire_count, 16'hFFFF);
    step(0,0,1,1,0,0, 4'd1, 16'h0001, 16'h0000);
    chk("wrap_zero", retire_count, 16'h0000);
    chk("wrap_valid", validW, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
